uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/hangman_pkg.sv | 15 +
 rtl/sync2.sv | 25 ++
 rtl/uart_rx.sv | 104 ++++++++++
 3 files changed

// File: rtl/hangman_pkg.sv
// hangman_pkg: shared UART timing constant and receiver state encoding.
// Ports: none (package).
package hangman_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 1250;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } rx_state_e;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous input, resets to 1 (idle line).
// Ports: clk, rst (sync active-high), async_in (raw input), sync_out (synchronized output).
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with mid-bit sampling and framing-error detection.
// Ports: clk, rst (sync active-high), rx_serial (async line, idles high),
//        rx_byte (last good byte), rx_ready (1-cycle good-frame pulse),
//        framing_error (1-cycle bad-stop pulse), busy (not IDLE).
module uart_rx
    import hangman_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       framing_error,
    output logic       busy
);

    localparam logic [15:0] HALF_TC = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_TC = 16'(CLKS_PER_BIT - 1);

    rx_state_e   state_q;
    logic [15:0] timer_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  rx_byte_q;
    logic        ready_q;
    logic        ferr_q;
    logic        rx_s;

    sync2 u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx_serial),
        .sync_out (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            rx_byte_q <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    idx_q   <= '0;
                    if (!rx_s) state_q <= START;
                end
                // Half-bit wait re-checks the start bit so short glitches are rejected.
                START: begin
                    if (timer_q == HALF_TC) begin
                        timer_q <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                DATA: begin
                    if (timer_q == FULL_TC) begin
                        timer_q        <= '0;
                        shift_q[idx_q] <= rx_s;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7) state_q <= STOP;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                STOP: begin
                    if (timer_q == FULL_TC) begin
                        timer_q <= '0;
                        if (rx_s) begin
                            rx_byte_q <= shift_q;
                            ready_q   <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK_WAIT;
                        end
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                // A low line after a bad stop bit is a break; wait for idle before rearming.
                BREAK_WAIT: begin
                    if (rx_s) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_ready      = ready_q;
    assign framing_error = ferr_q;
    assign busy          = (state_q != IDLE);

endmodule
